// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ha_cell.sv
// Half-adder cell; two of these plus an OR form the shared full adder.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first, one bit per clock,
// through a single shared full adder, with a start/busy/done handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic halfSum, halfCarry, fullCarry2, sBit, cBit;
    logic unusedAccLsb;

    ha_cell u_haOperands (
        .a(a_q[0]),
        .b(b_q[0]),
        .s(halfSum),
        .c(halfCarry)
    );

    ha_cell u_haCarry (
        .a(halfSum),
        .b(carry_q),
        .s(sBit),
        .c(fullCarry2)
    );

    assign cBit = halfCarry | fullCarry2;

    // The accumulator LSB is only ever the initial zero fill being shifted out.
    assign unusedAccLsb = acc_q[0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d   = {sBit, acc_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = cBit;
                if (cnt_q == LAST_BIT) begin
                    // Result is published only here, so an aborted add never leaks out.
                    sum_d   = {sBit, acc_q[WIDTH-1:1]};
                    cout_d  = cBit;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl with hand-computed results.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] opA;
    logic [7:0] opB;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checkCount = 0;
    int passCount  = 0;
    logic [7:0] prevSum  = 8'h00;
    logic       prevCout = 1'b0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op_a(opA),
        .op_b(opB),
        .cin(cin),
        .busy(busy),
        .done(done),
        .sum(sum),
        .cout(cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ci);
        opA   = a;
        opB   = b;
        cin   = ci;
        start = 1'b1;
    endtask

    // One full add: accept, eight RUN cycles, one DONE cycle, then back to IDLE.
    task automatic runAdd(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] expSum, input logic expCout,
                          input bit holdStart, input bit meddle);
        applyStimulus(a, b, ci);
        tick();
        if (!holdStart) start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checkOutput("runBusy", 32'(busy), 32'd1);
            checkOutput("runDone", 32'(done), 32'd0);
            if (i == 1 || i == 8) begin
                checkOutput("sumHold", 32'(sum), 32'(prevSum));
                checkOutput("coutHold", 32'(cout), 32'(prevCout));
            end
            if (meddle) begin
                start = 1'b1;
                opA   = 8'hA5 ^ 8'(i);
                opB   = 8'h5A;
                cin   = 1'b1;
            end
            tick();
        end
        if (meddle) start = 1'b0;
        checkOutput("doneFlag", 32'(done), 32'd1);
        checkOutput("doneBusy", 32'(busy), 32'd0);
        checkOutput("sum", 32'(sum), 32'(expSum));
        checkOutput("cout", 32'(cout), 32'(expCout));
        prevSum  = expSum;
        prevCout = expCout;
        tick();
        checkOutput("afterDone", 32'(done), 32'd0);
        checkOutput("afterBusy", 32'(busy), 32'd0);
        checkOutput("afterSum", 32'(sum), 32'(expSum));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        opA   = 8'h00;
        opB   = 8'h00;
        cin   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstSum", 32'(sum), 32'd0);
        checkOutput("rstCout", 32'(cout), 32'd0);

        for (int i = 0; i < 20; i++) begin
            checkOutput("idleOutputs", {21'd0, busy, done, sum, cout}, 32'd0);
            tick();
        end

        runAdd(8'h3A, 8'h45, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
        runAdd(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        runAdd(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        runAdd(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("singleDone", 32'(done), 32'd0);
            tick();
        end

        // Abort an add part way through with a one-edge reset.
        applyStimulus(8'h11, 8'h22, 1'b0);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("preAbortBusy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortSum", 32'(sum), 32'd0);
        checkOutput("abortCout", 32'(cout), 32'd0);
        prevSum  = 8'h00;
        prevCout = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checkOutput("noDoneAfterAbort", {30'd0, busy, done}, 32'd0);
            tick();
        end
        runAdd(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);

        // Continuous start: one completion every WIDTH+2 cycles.
        for (int r = 0; r < 3; r++) begin
            runAdd(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0);
        end
        start = 1'b0;
        tick();
        tick();
        checkOutput("finalIdle", {30'd0, busy, done}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
